// File: rtl/uart_recv.sv
// ---------------------------------------------------------------------------
// uart_recv
//   8N1 UART receiver, LSB first. The serial line is synchronized with two
//   flops plus one history flop. A falling edge on the synchronized line
//   starts a frame. Each bit is sampled at the middle of its bit period. A
//   byte is published on uart_data together with a one-cycle uart_done pulse
//   when the stop bit samples high. A low stop bit instead gives a one-cycle
//   uart_frame_err pulse, and uart_data keeps its previous value.
//
//   Build option:
//     UART_RX_MAJORITY_EN - when defined, each bit value is the 2-of-3 majority
//                           of the synchronized samples taken at mid-1, mid
//                           and mid+1. The decision is made at mid+1.
//                           When undefined, a single sample is taken at mid.
//
//   Parameters:
//     CLK_FREQ  system clock frequency in Hz
//     UART_BPS  baud rate; BPS_CNT = CLK_FREQ/UART_BPS clocks per bit
//
//   Ports:
//     sys_clk         in   system clock, rising edge
//     sys_rst         in   asynchronous active-high reset
//     uart_rxd        in   asynchronous serial input, idles high
//     uart_data       out  [7:0] last correctly received byte
//     uart_done       out  one-cycle pulse, new byte on uart_data
//     uart_frame_err  out  one-cycle pulse, stop bit sampled low
//     uart_rx_busy    out  high while a frame is being received
// ---------------------------------------------------------------------------
module uart_recv #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       uart_frame_err,
    output logic       uart_rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_CNT / 2);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BPS_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(BPS_CNT / 2 + 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       data_q,      data_d;
    logic             done_q,      done_d;
    logic             ferr_q,      ferr_d;
    logic             rxd_sync1_q, rxd_sync1_d;
    logic             rxd_sync2_q, rxd_sync2_d;
    logic             rxd_hist_q,  rxd_hist_d;

    logic             rxd_fall;
    logic             cnt_wrap;
    logic [CNT_W-1:0] cnt_next;
    logic             sample_now;
    logic             bit_val;

`ifdef UART_RX_MAJORITY_EN
    logic maj_a_q, maj_a_d;
    logic maj_b_q, maj_b_d;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    // Synchronizer chain and history flop
    always_comb begin
        rxd_sync1_d = uart_rxd;
        rxd_sync2_d = rxd_sync1_q;
        rxd_hist_d  = rxd_sync2_q;
    end

    assign rxd_fall = rxd_hist_q & ~rxd_sync2_q;
    assign cnt_wrap = (clk_cnt_q == CNT_LAST);
    assign cnt_next = cnt_wrap ? '0 : clk_cnt_q + 1'b1;

`ifdef UART_RX_MAJORITY_EN
    // The first two votes are captured one and two cycles before the decision.
    // The third vote is the live synchronized value at mid+1.
    always_comb begin
        maj_a_d = maj_a_q;
        maj_b_d = maj_b_q;
        if (clk_cnt_q == CNT_PRE) begin
            maj_a_d = rxd_sync2_q;
        end
        if (clk_cnt_q == CNT_MID) begin
            maj_b_d = rxd_sync2_q;
        end
    end

    assign sample_now = (clk_cnt_q == CNT_POST);
    assign bit_val    = majority3(maj_a_q, maj_b_q, rxd_sync2_q);
`else
    assign sample_now = (clk_cnt_q == CNT_MID);
    assign bit_val    = rxd_sync2_q;
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = 3'd0;
                if (rxd_fall) begin
                    state_d = START;
                end
            end

            START: begin
                clk_cnt_d = cnt_next;
                if (sample_now && bit_val) begin
                    // The line went high again before mid-bit, so treat it as a glitch.
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                end else if (cnt_wrap) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end

            DATA: begin
                clk_cnt_d = cnt_next;
                if (sample_now) begin
                    shift_d[bit_idx_q] = bit_val;
                end
                if (cnt_wrap) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                clk_cnt_d = cnt_next;
                // Leave at mid-stop. The remaining half bit is idle time, so a
                // start edge right after the stop bit is still seen.
                if (sample_now) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                    if (bit_val) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // State registers. The synchronizer resets high so an idle line does not
    // look like a start edge after reset is released.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            rxd_sync1_q <= 1'b1;
            rxd_sync2_q <= 1'b1;
            rxd_hist_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
            rxd_sync1_q <= rxd_sync1_d;
            rxd_sync2_q <= rxd_sync2_d;
            rxd_hist_q  <= rxd_hist_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
        end else begin
            maj_a_q <= maj_a_d;
            maj_b_q <= maj_b_d;
        end
    end
`endif

    assign uart_data      = data_q;
    assign uart_done      = done_q;
    assign uart_frame_err = ferr_q;
    assign uart_rx_busy   = (state_q != IDLE);

endmodule
